// File: rtl/interboard_tx_arbiter_if.sv
// rtl/interboard_tx_arbiter_if.sv - requester-side and link-side signals of the interboard transmit arbiter
interface interboard_tx_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [3*N_REQ-1:0] req_msg_type;
  logic [5*N_REQ-1:0] req_number;
  logic [N_REQ-1:0]   req_accept;
  logic [N_REQ-1:0]   req_done;
  logic               inter_ready;
  logic               transmit;
  logic               ctrl_en;
  logic [2:0]         ctrl_msg_type;
  logic [4:0]         ctrl_number;

  // master: the arbiter, which owns the link and answers the requesters
  modport master (
    input  req_valid, req_msg_type, req_number, inter_ready,
    output req_accept, req_done, transmit, ctrl_en, ctrl_msg_type, ctrl_number
  );

  modport slave (
    output req_valid, req_msg_type, req_number, inter_ready,
    input  req_accept, req_done, transmit, ctrl_en, ctrl_msg_type, ctrl_number
  );
endinterface

// File: rtl/interboard_tx_arbiter.sv
// rtl/interboard_tx_arbiter.sv - round-robin owner of the shared interboard transmit channel
// Retransmission on ack timeout is enabled by defining INTERBOARD_TX_RETRY_EN.
module interboard_tx_arbiter #(
  parameter int N_REQ     = 2,
  parameter int TIMEOUT   = 1024,
  parameter int MAX_RETRY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    interboard_rst,
  interboard_tx_arbiter_if.master bus,
  output logic                    busy,
  output logic                    tx_error
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, DONE} state_t;

  state_t        state, state_nxt;
  logic          clr;
  logic [GW-1:0] last_grant, grant, cand;
  logic          grant_found, accept;
  logic [2:0]    sel_type;
  logic [4:0]    sel_number;
  logic [TW-1:0] timer;
  logic          timeout_hit, give_up, retry_ok;

  assign clr = rst | interboard_rst;

  // Scan from farthest to nearest so the requester right after last_grant wins.
  always_comb begin
    grant       = last_grant;
    grant_found = 1'b0;
    cand        = last_grant;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = GW'((int'(last_grant) + i) % N_REQ);
      if (bus.req_valid[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_type   = '0;
    sel_number = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == GW'(i)) begin
        sel_type   = bus.req_msg_type[3*i +: 3];
        sel_number = bus.req_number[5*i +: 5];
      end
    end
  end

  assign accept = (state == IDLE) && grant_found && !clr;

  always_comb begin
    bus.req_accept = '0;
    if (accept) bus.req_accept[grant] = 1'b1;
  end

  assign timeout_hit = (state == WAIT_ACK) && (timer == TW'(TIMEOUT - 1));

`ifdef INTERBOARD_TX_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt;

  assign retry_ok = retry_cnt < RW'(MAX_RETRY);

  always_ff @(posedge clk) begin
    if (clr || accept) retry_cnt <= '0;
    else if (timeout_hit && !bus.inter_ready && retry_ok) retry_cnt <= retry_cnt + 1'b1;
  end
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
  assign retry_ok         = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    give_up   = 1'b0;
    case (state)
      IDLE:     if (grant_found) state_nxt = SEND;
      SEND:     state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.inter_ready) state_nxt = DONE;
        else if (timeout_hit) begin
          if (retry_ok) state_nxt = SEND;
          else begin
            give_up   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      give_up   = 1'b0;
    end
  end

  // Link outputs are decoded from the next state so they line up with it without glitches.
  always_ff @(posedge clk) begin
    if (clr) begin
      state             <= IDLE;
      last_grant        <= GW'(N_REQ - 1);
      timer             <= '0;
      bus.transmit      <= 1'b0;
      bus.ctrl_en       <= 1'b0;
      bus.ctrl_msg_type <= '0;
      bus.ctrl_number   <= '0;
      bus.req_done      <= '0;
      busy              <= 1'b0;
      tx_error          <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= (state == WAIT_ACK) ? timer + 1'b1 : '0;
      bus.transmit <= (state_nxt == SEND);
      bus.ctrl_en  <= (state_nxt == SEND) || (state_nxt == WAIT_ACK);
      busy         <= (state_nxt != IDLE);
      bus.req_done <= '0;
      if (state_nxt == DONE) bus.req_done[last_grant] <= 1'b1;
      if (accept) begin
        last_grant        <= grant;
        bus.ctrl_msg_type <= sel_type;
        bus.ctrl_number   <= sel_number;
        tx_error          <= 1'b0;
      end else if (give_up) begin
        tx_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_interboard_tx_arbiter.sv
// tb/tb_interboard_tx_arbiter.sv - directed and randomized self-checking bench for interboard_tx_arbiter
module tb_interboard_tx_arbiter;
  localparam int N_REQ     = 2;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 3;
`ifdef INTERBOARD_TX_RETRY_EN
  localparam int ATTEMPTS = MAX_RETRY + 1;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic interboard_rst = 1'b0;
  logic busy, tx_error;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc_no = 0;

  interboard_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  interboard_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .interboard_rst(interboard_rst), .bus(bus), .busy(busy), .tx_error(tx_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ownership tracked as the age in cycles since the last transmit pulse.
  bit             m_en = 1'b0;
  bit             m_owned = 1'b0, m_retire = 1'b0, m_err = 1'b0;
  int             m_owner = 0, m_last = N_REQ - 1, m_age = 0, m_tx = 0;
  logic [2:0]     m_type = '0;
  logic [4:0]     m_num = '0;
  int             pick, cidx;
  logic [N_REQ-1:0] e_acc, e_done, vsnap;

  always @(negedge clk) begin
    if (m_en) begin
      pick  = -1;
      vsnap = bus.req_valid;
      if (!m_owned && !m_retire && !(rst || interboard_rst)) begin
        for (int k = 1; k <= N_REQ; k++) begin
          cidx = (m_last + k) % N_REQ;
          if (pick < 0 && vsnap[cidx]) pick = cidx;
        end
      end
      e_acc  = '0;
      e_done = '0;
      if (pick >= 0) e_acc[pick] = 1'b1;
      if (m_retire) e_done[m_owner] = 1'b1;
      check("req_accept", bus.req_accept, e_acc);
      check("transmit", bus.transmit, m_owned && (m_age == 0));
      check("ctrl_en", bus.ctrl_en, m_owned);
      check("busy", busy, m_owned || m_retire);
      check("req_done", bus.req_done, e_done);
      check("tx_error", tx_error, m_err);
      check("ctrl_msg_type", bus.ctrl_msg_type, m_type);
      check("ctrl_number", bus.ctrl_number, m_num);
      if (rst || interboard_rst) begin
        m_owned = 0; m_retire = 0; m_err = 0; m_last = N_REQ - 1; m_type = '0; m_num = '0;
      end else if (m_retire) begin
        m_retire = 0;
      end else if (m_owned) begin
        if (m_age >= 1 && bus.inter_ready) begin
          m_owned = 0; m_retire = 1;
        end else if (m_age == TIMEOUT) begin
          if (m_tx < ATTEMPTS) begin
            m_age = 0; m_tx++;
          end else begin
            m_owned = 0; m_retire = 1; m_err = 1;
          end
        end else begin
          m_age++;
        end
      end else if (pick >= 0) begin
        m_owned = 1; m_owner = pick; m_last = pick; m_age = 0; m_tx = 1; m_err = 0;
        m_type  = bus.req_msg_type[3*pick +: 3];
        m_num   = bus.req_number[5*pick +: 5];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
    tick();
  endtask

  logic [N_REQ-1:0] acc, vld;
  logic [3*N_REQ-1:0] typ;
  logic [5*N_REQ-1:0] num;
  int grants[4], acc_cyc[4], tx_cyc[8], exp_g[4];
  int n_acc, n_tx, done_cyc, ack_div;
  bit got_done;
  logic err_at_done;

  initial begin
    bus.req_valid = '0; bus.req_msg_type = '0; bus.req_number = '0; bus.inter_ready = 1'b0;
    exp_g = '{0, 1, 0, 1};
    tick(); tick();
    m_en = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_ctrl_en", bus.ctrl_en, 0);
    check("reset_tx_error", tx_error, 0);
    rst = 1'b0;
    tick();

    // single request
    bus.req_valid = 2'b01; bus.req_msg_type = 6'd2; bus.req_number = 10'd17;
    @(negedge clk); check("single_accept", bus.req_accept, 2'b01);
    tick(); bus.req_valid = 2'b00;
    @(negedge clk);
    check("single_transmit", bus.transmit, 1);
    check("single_type", bus.ctrl_msg_type, 2);
    check("single_number", bus.ctrl_number, 17);
    tick(); tick(); tick(); bus.inter_ready = 1'b1;
    @(negedge clk); check("single_no_early_done", bus.req_done, 0);
    tick(); bus.inter_ready = 1'b0;
    @(negedge clk);
    check("single_done", bus.req_done, 2'b01);
    check("single_tx_error", tx_error, 0);
    tick();

    // contention after a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req_valid = 2'b11; bus.req_msg_type = {3'd5, 3'd1}; bus.req_number = {5'd20, 5'd10};
    bus.inter_ready = 1'b1;
    n_acc = 0;
    for (int k = 0; k < 40 && n_acc < 4; k++) begin
      @(negedge clk);
      acc = bus.req_accept;
      if (acc != 0) begin
        grants[n_acc]  = acc[1] ? 1 : 0;
        acc_cyc[n_acc] = cyc_no;
        n_acc++;
      end
      tick();
      if (acc[0]) bus.req_number[4:0] = bus.req_number[4:0] + 5'd1;
      if (acc[1]) bus.req_number[9:5] = bus.req_number[9:5] + 5'd1;
    end
    check("contention_count", n_acc, 4);
    for (int k = 0; k < 4; k++) check("contention_grant", grants[k], exp_g[k]);
    check("contention_spacing", acc_cyc[1] - acc_cyc[0], 4);
    bus.req_valid = 2'b00;
    wait_idle("contention_idle");
    bus.inter_ready = 1'b0;

    // stray acks in IDLE and SEND
    bus.inter_ready = 1'b1; tick(); bus.inter_ready = 1'b0;
    @(negedge clk); check("stray_idle_busy", busy, 0);
    tick();
    bus.req_valid = 2'b01; bus.req_number[4:0] = 5'd3;
    @(negedge clk); check("stray_accept", bus.req_accept, 2'b01);
    tick(); bus.req_valid = 2'b00; bus.inter_ready = 1'b1;
    @(negedge clk); check("stray_send_transmit", bus.transmit, 1);
    tick(); bus.inter_ready = 1'b0;
    tick();
    @(negedge clk);
    check("stray_still_owned", bus.ctrl_en, 1);
    check("stray_no_done", bus.req_done, 0);
    tick(); bus.inter_ready = 1'b1;
    tick(); bus.inter_ready = 1'b0;
    @(negedge clk); check("stray_done", bus.req_done, 2'b01);
    tick();

    // no ack at all
    bus.req_valid = 2'b10; bus.req_msg_type[5:3] = 3'd6;
    @(negedge clk); check("noack_accept", bus.req_accept, 2'b10);
    tick(); bus.req_valid = 2'b00;
    n_tx = 0; got_done = 0; done_cyc = 0; err_at_done = 1'b0;
    for (int k = 0; k < 80 && !got_done; k++) begin
      @(negedge clk);
      if (bus.transmit && n_tx < 8) begin tx_cyc[n_tx] = cyc_no; n_tx++; end
      if (bus.req_done != 0) begin got_done = 1; done_cyc = cyc_no; err_at_done = tx_error; end
      tick();
    end
    check("noack_done_seen", got_done, 1);
    check("noack_tx_count", n_tx, ATTEMPTS);
    for (int k = 1; k < n_tx; k++) check("noack_tx_spacing", tx_cyc[k] - tx_cyc[k-1], TIMEOUT + 1);
    if (n_tx > 0) check("noack_done_gap", done_cyc - tx_cyc[n_tx-1], TIMEOUT + 1);
    check("noack_tx_error", err_at_done, 1);
    @(negedge clk); check("noack_error_sticky", tx_error, 1);
    tick(); bus.req_valid = 2'b01;
    @(negedge clk); check("clear_accept", bus.req_accept, 2'b01);
    tick(); bus.req_valid = 2'b00;
    @(negedge clk); check("clear_tx_error", tx_error, 0);
    bus.inter_ready = 1'b1;
    wait_idle("clear_idle");
    bus.inter_ready = 1'b0;

    // ack on the last WAIT_ACK cycle
    bus.req_valid = 2'b01;
    @(negedge clk); check("coinc_accept", bus.req_accept, 2'b01);
    tick(); bus.req_valid = 2'b00;
    @(negedge clk); check("coinc_transmit", bus.transmit, 1);
    repeat (TIMEOUT) tick();
    bus.inter_ready = 1'b1;
    tick(); bus.inter_ready = 1'b0;
    @(negedge clk);
    check("coinc_done", bus.req_done, 2'b01);
    check("coinc_tx_error", tx_error, 0);
    check("coinc_no_retransmit", bus.transmit, 0);
    tick();

    // interboard_rst while waiting for an ack
    bus.req_valid = 2'b01;
    @(negedge clk); check("midrst_accept0", bus.req_accept, 2'b01);
    tick(); bus.req_valid = 2'b10;
    tick(); interboard_rst = 1'b1;
    tick(); interboard_rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_ctrl_en", bus.ctrl_en, 0);
    check("midrst_no_done", bus.req_done, 0);
    check("midrst_ctrl_number", bus.ctrl_number, 0);
    check("midrst_grant1", bus.req_accept, 2'b10);
    tick(); bus.req_valid = 2'b11;
    tick(); interboard_rst = 1'b1;
    tick(); interboard_rst = 1'b0;
    @(negedge clk); check("midrst_grant0_first", bus.req_accept, 2'b01);
    tick(); bus.req_valid = 2'b00; bus.inter_ready = 1'b1;
    wait_idle("midrst_idle");
    bus.inter_ready = 1'b0;

    // randomized traffic
    ack_div = 4;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acc = bus.req_accept;
      tick();
      if (cyc % 250 == 0) ack_div = $urandom_range(1, 14);
      bus.inter_ready = ($urandom_range(1, ack_div) == 1);
      interboard_rst  = ($urandom_range(0, 199) == 0);
      vld = bus.req_valid; typ = bus.req_msg_type; num = bus.req_number;
      for (int i = 0; i < N_REQ; i++) begin
        if (acc[i] || (!vld[i] && $urandom_range(0, 3) == 0)) begin
          vld[i] = acc[i] ? ($urandom_range(0, 1) == 1) : 1'b1;
          typ[3*i +: 3] = 3'($urandom);
          num[5*i +: 5] = 5'($urandom);
        end else if (vld[i] && $urandom_range(0, 63) == 0) begin
          vld[i] = 1'b0;
        end
      end
      bus.req_valid = vld; bus.req_msg_type = typ; bus.req_number = num;
    end
    interboard_rst = 1'b0; bus.req_valid = '0; bus.inter_ready = 1'b1;
    wait_idle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
